// File: rtl/tt_mask_idx_agu.sv
// Mask/index address generator: buffers mask/index items in a credit-backed FIFO
// and expands them into per-element LSU requests for strided or indexed memops.
module tt_mask_idx_agu #(
  parameter int VLEN         = 256,
  parameter int MASK_CREDITS = 2,
  localparam int EW          = $clog2(VLEN + 1)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic          i_is_indexed,
  input  logic [EW-1:0] i_vl,
  input  logic [63:0]   i_base_addr,
  input  logic [63:0]   i_stride,
  input  logic [64:0]   i_mask_idx_item,
  input  logic          i_mask_idx_valid,
  output logic          o_mask_idx_credit,
  output logic          o_req_valid,
  input  logic          i_req_ready,
  output logic [63:0]   o_req_addr,
  output logic [EW-1:0] o_req_elem,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err
);

  localparam int PW = (MASK_CREDITS > 1) ? $clog2(MASK_CREDITS) : 1;
  localparam int CW = $clog2(MASK_CREDITS + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(MASK_CREDITS - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(MASK_CREDITS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic          is_indexed_q;
  logic [EW-1:0] vl_q;
  logic [EW-1:0] elem;
  logic [63:0]   stride_q;
  logic [63:0]   addr_acc;

  logic [64:0]   fifo_mem [MASK_CREDITS];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] fifo_cnt;

  logic          fifo_full;
  logic          head_valid;
  logic          push_ok;
  logic          pop;
  logic [64:0]   head;
  logic [63:0]   head_word;
  logic          slot_free;
  logic          strided_zero;
  logic          step;
  logic          mask_bit;
  logic          load_req;
  logic          elem_done;

  always_comb begin
    head       = fifo_mem[rd_ptr];
    head_word  = head[63:0];
    fifo_full  = (fifo_cnt == FULL_CNT);
    head_valid = (fifo_cnt != '0);
    push_ok    = i_mask_idx_valid && (!fifo_full || pop);
  end

  // Step/pop decisions; a full FIFO can still accept a push when the head pops.
  always_comb begin
    slot_free    = !o_req_valid || i_req_ready;
    strided_zero = !is_indexed_q && (vl_q == '0);
    step         = (state == RUN) && head_valid && slot_free && (elem < vl_q);
    mask_bit     = head_word[elem[5:0]];
    load_req     = step && (is_indexed_q ? head[64] : mask_bit);
    pop          = ((state == RUN) && strided_zero && head_valid) ||
                   (step && (is_indexed_q || (elem[5:0] == 6'h3f) ||
                             (elem == vl_q - EW'(1))));
    elem_done    = (state == RUN) && !strided_zero && (elem == vl_q) && slot_free;
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= i_mask_idx_item;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      fifo_cnt          <= '0;
      o_mask_idx_credit <= 1'b0;
      o_err             <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
      if (pop)     rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      o_mask_idx_credit <= pop;
      if (i_mask_idx_valid && fifo_full && !pop) o_err <= 1'b1;
    end
  end

  // In indexed mode addr_acc simply holds the base address.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= IDLE;
      is_indexed_q <= 1'b0;
      vl_q         <= '0;
      stride_q     <= '0;
      addr_acc     <= '0;
      elem         <= '0;
      o_req_valid  <= 1'b0;
      o_req_addr   <= '0;
      o_req_elem   <= '0;
      o_done       <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            is_indexed_q <= i_is_indexed;
            vl_q         <= i_vl;
            stride_q     <= i_stride;
            addr_acc     <= i_base_addr;
            elem         <= '0;
            if (i_is_indexed && (i_vl == '0)) begin
              state  <= DONE;
              o_done <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (step) begin
            elem <= elem + EW'(1);
            if (!is_indexed_q) addr_acc <= addr_acc + stride_q;
          end
          if (load_req) begin
            o_req_valid <= 1'b1;
            o_req_addr  <= is_indexed_q ? addr_acc + head_word : addr_acc;
            o_req_elem  <= elem;
          end else if (i_req_ready) begin
            o_req_valid <= 1'b0;
          end
          if ((strided_zero && head_valid) || elem_done) begin
            state  <= DONE;
            o_done <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb o_busy = (state != IDLE);

endmodule

// File: tb/tb_tt_mask_idx_agu.sv
// Directed self-checking bench for tt_mask_idx_agu: strided, indexed, stall,
// overflow, zero-length and async-reset scenarios with hand-computed results.
module tb_tt_mask_idx_agu;

  localparam int VLEN         = 256;
  localparam int MASK_CREDITS = 2;
  localparam int EW           = $clog2(VLEN + 1);

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_start;
  logic          i_is_indexed;
  logic [EW-1:0] i_vl;
  logic [63:0]   i_base_addr;
  logic [63:0]   i_stride;
  logic [64:0]   i_mask_idx_item;
  logic          i_mask_idx_valid;
  logic          o_mask_idx_credit;
  logic          o_req_valid;
  logic          i_req_ready;
  logic [63:0]   o_req_addr;
  logic [EW-1:0] o_req_elem;
  logic          o_busy;
  logic          o_done;
  logic          o_err;

  tt_mask_idx_agu #(.VLEN(VLEN), .MASK_CREDITS(MASK_CREDITS)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_is_indexed(i_is_indexed),
    .i_vl(i_vl), .i_base_addr(i_base_addr), .i_stride(i_stride),
    .i_mask_idx_item(i_mask_idx_item), .i_mask_idx_valid(i_mask_idx_valid),
    .o_mask_idx_credit(o_mask_idx_credit), .o_req_valid(o_req_valid),
    .i_req_ready(i_req_ready), .o_req_addr(o_req_addr), .o_req_elem(o_req_elem),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int credit_cnt = 0;
  int credits_total = 0;
  int done_total = 0;
  int done_cyc = 0;
  int last_hs_cyc = 0;
  int pushes_sent = 0;
  logic [63:0] req_addr_q[$];
  int          req_elem_q[$];
  int          credit_elem_q[$];

  always @(posedge i_clk) cyc++;

  // Observe handshakes, credits and done pulses mid-cycle, away from the edge.
  always @(negedge i_clk) begin
    if (!i_reset) begin
      if (o_req_valid && i_req_ready) begin
        req_addr_q.push_back(o_req_addr);
        req_elem_q.push_back(int'(o_req_elem));
        last_hs_cyc = cyc;
      end
      if (o_mask_idx_credit) begin
        credit_cnt++;
        credits_total++;
        credit_elem_q.push_back(int'(o_req_elem));
      end
      if (o_done) begin
        done_total++;
        done_cyc = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clearMon();
    req_addr_q.delete();
    req_elem_q.delete();
    credit_elem_q.delete();
    credit_cnt = 0;
  endtask

  function automatic logic [63:0] qAddr(input int i);
    return (i < req_addr_q.size()) ? req_addr_q[i] : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  function automatic int qElem(input int i);
    return (i < req_elem_q.size()) ? req_elem_q[i] : -1;
  endfunction

  function automatic int qCreditElem(input int i);
    return (i < credit_elem_q.size()) ? credit_elem_q[i] : -1;
  endfunction

  task automatic applyStimulus(input logic indexed, input int vl,
                               input logic [63:0] base, input logic [63:0] stride);
    i_is_indexed = indexed;
    i_vl         = EW'(vl);
    i_base_addr  = base;
    i_stride     = stride;
    i_start      = 1'b1;
    tick();
    i_start      = 1'b0;
  endtask

  task automatic pushItem(input logic [64:0] item);
    int budget = 300;
    while ((pushes_sent - credits_total) >= MASK_CREDITS && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) checkOutput("push_credit_wait", 64'd0, 64'd1);
    i_mask_idx_item  = item;
    i_mask_idx_valid = 1'b1;
    tick();
    i_mask_idx_valid = 1'b0;
    pushes_sent++;
  endtask

  task automatic waitDone(input string tag, input int budget);
    int start = done_total;
    int n = 0;
    while (done_total == start && n < budget) begin
      tick();
      n++;
    end
    checkOutput(tag, 64'(done_total > start), 64'd1);
    tick();
  endtask

  task automatic waitReqValid(input string tag, input int budget);
    int n = 0;
    while (!o_req_valid && n < budget) begin
      tick();
      n++;
    end
    checkOutput(tag, 64'(o_req_valid), 64'd1);
  endtask

  initial begin
    int bad;
    i_reset          = 1'b1;
    i_start          = 1'b0;
    i_is_indexed     = 1'b0;
    i_vl             = '0;
    i_base_addr      = '0;
    i_stride         = '0;
    i_mask_idx_item  = '0;
    i_mask_idx_valid = 1'b0;
    i_req_ready      = 1'b0;
    tick();
    tick();
    checkOutput("rst_req_valid", 64'(o_req_valid), 64'd0);
    checkOutput("rst_busy", 64'(o_busy), 64'd0);
    checkOutput("rst_done", 64'(o_done), 64'd0);
    checkOutput("rst_err", 64'(o_err), 64'd0);
    checkOutput("rst_credit", 64'(o_mask_idx_credit), 64'd0);
    checkOutput("rst_addr", o_req_addr, 64'd0);
    i_reset = 1'b0;
    tick();

    // Strided vl=3, mask 0b101
    $display("[TB] strided vl=3");
    clearMon();
    i_req_ready = 1'b1;
    applyStimulus(1'b0, 3, 64'h1000, 64'd8);
    checkOutput("t1_busy", 64'(o_busy), 64'd1);
    pushItem({1'b0, 64'b101});
    checkOutput("t1_lat_n1", 64'(o_req_valid), 64'd0);
    tick();
    checkOutput("t1_lat_n2", 64'(o_req_valid), 64'd1);
    checkOutput("t1_first_addr", o_req_addr, 64'h1000);
    waitDone("t1_done", 50);
    checkOutput("t1_nreq", 64'(req_addr_q.size()), 64'd2);
    checkOutput("t1_addr0", qAddr(0), 64'h1000);
    checkOutput("t1_elem0", 64'(qElem(0)), 64'd0);
    checkOutput("t1_addr1", qAddr(1), 64'h1010);
    checkOutput("t1_elem1", 64'(qElem(1)), 64'd2);
    checkOutput("t1_credits", 64'(credit_cnt), 64'd1);
    checkOutput("t1_done_lat", 64'(done_cyc - last_hs_cyc), 64'd1);
    checkOutput("t1_idle", 64'(o_busy), 64'd0);

    // Strided vl=130 across three mask words
    $display("[TB] strided vl=130");
    clearMon();
    applyStimulus(1'b0, 130, 64'h8000, 64'd4);
    for (int i = 0; i < 3; i++) pushItem({1'b0, 64'hFFFF_FFFF_FFFF_FFFF});
    waitDone("t2_done", 400);
    checkOutput("t2_nreq", 64'(req_addr_q.size()), 64'd130);
    checkOutput("t2_last_addr", qAddr(129), 64'h8204);
    checkOutput("t2_last_elem", 64'(qElem(129)), 64'd129);
    bad = 0;
    for (int i = 0; i < req_addr_q.size(); i++)
      if (req_addr_q[i] !== 64'h8000 + 64'(i * 4) || req_elem_q[i] != i) bad++;
    checkOutput("t2_sequence", 64'(bad), 64'd0);
    checkOutput("t2_credits", 64'(credit_cnt), 64'd3);
    checkOutput("t2_pop0", 64'(qCreditElem(0)), 64'd63);
    checkOutput("t2_pop1", 64'(qCreditElem(1)), 64'd127);
    checkOutput("t2_pop2", 64'(qCreditElem(2)), 64'd129);

    // Indexed vl=4 with one masked-off index and a negative offset
    $display("[TB] indexed vl=4");
    clearMon();
    applyStimulus(1'b1, 4, 64'h2000, 64'd0);
    pushItem({1'b1, 64'h10});
    pushItem({1'b0, 64'hDEAD});
    pushItem({1'b1, 64'hFFFF_FFFF_FFFF_FFF8});
    pushItem({1'b1, 64'h0});
    waitDone("t3_done", 100);
    checkOutput("t3_nreq", 64'(req_addr_q.size()), 64'd3);
    checkOutput("t3_addr0", qAddr(0), 64'h2010);
    checkOutput("t3_elem0", 64'(qElem(0)), 64'd0);
    checkOutput("t3_addr1", qAddr(1), 64'h1FF8);
    checkOutput("t3_elem1", 64'(qElem(1)), 64'd2);
    checkOutput("t3_addr2", qAddr(2), 64'h2000);
    checkOutput("t3_elem2", 64'(qElem(2)), 64'd3);
    checkOutput("t3_credits", 64'(credit_cnt), 64'd4);

    // Backpressure on the first request
    $display("[TB] backpressure");
    clearMon();
    i_req_ready = 1'b0;
    applyStimulus(1'b0, 2, 64'h3000, 64'h10);
    pushItem({1'b0, 64'b11});
    waitReqValid("t4_req_up", 20);
    for (int i = 0; i < 5; i++) begin
      checkOutput("t4_hold_addr", o_req_addr, 64'h3000);
      checkOutput("t4_hold_elem", 64'(o_req_elem), 64'd0);
      tick();
    end
    checkOutput("t4_stall_credits", 64'(credit_cnt), 64'd0);
    checkOutput("t4_stall_nreq", 64'(req_addr_q.size()), 64'd0);
    i_req_ready = 1'b1;
    waitDone("t4_done", 50);
    checkOutput("t4_nreq", 64'(req_addr_q.size()), 64'd2);
    checkOutput("t4_addr0", qAddr(0), 64'h3000);
    checkOutput("t4_addr1", qAddr(1), 64'h3010);
    checkOutput("t4_elem1", 64'(qElem(1)), 64'd1);
    checkOutput("t4_credits", 64'(credit_cnt), 64'd1);

    // Overflow while idle, then drain stale words with zero-length strided ops
    $display("[TB] overflow and vl=0");
    clearMon();
    i_mask_idx_valid = 1'b1;
    i_mask_idx_item  = {1'b0, 64'h1111};
    tick();
    i_mask_idx_item  = {1'b0, 64'h2222};
    tick();
    i_mask_idx_valid = 1'b0;
    checkOutput("t5_err_clear", 64'(o_err), 64'd0);
    i_mask_idx_valid = 1'b1;
    i_mask_idx_item  = {1'b0, 64'h3333};
    tick();
    i_mask_idx_valid = 1'b0;
    pushes_sent += 2;
    checkOutput("t5_err_set", 64'(o_err), 64'd1);
    tick();
    tick();
    checkOutput("t5_err_sticky", 64'(o_err), 64'd1);
    for (int k = 0; k < 2; k++) begin
      clearMon();
      applyStimulus(1'b0, 0, 64'h7000, 64'd8);
      waitDone("t5_vl0_done", 20);
      checkOutput("t5_vl0_nreq", 64'(req_addr_q.size()), 64'd0);
      checkOutput("t5_vl0_credits", 64'(credit_cnt), 64'd1);
    end
    checkOutput("t5_err_still", 64'(o_err), 64'd1);

    // Async reset in the middle of a stalled request
    $display("[TB] async reset mid-run");
    clearMon();
    i_req_ready = 1'b0;
    applyStimulus(1'b0, 4, 64'h4000, 64'd1);
    pushItem({1'b0, 64'hF});
    waitReqValid("t6_req_up", 20);
    #2;
    i_reset = 1'b1;
    #1;
    checkOutput("t6_rst_valid", 64'(o_req_valid), 64'd0);
    checkOutput("t6_rst_busy", 64'(o_busy), 64'd0);
    checkOutput("t6_rst_addr", o_req_addr, 64'd0);
    checkOutput("t6_rst_err", 64'(o_err), 64'd0);
    tick();
    i_reset = 1'b0;
    pushes_sent = credits_total;
    tick();
    clearMon();
    i_req_ready = 1'b1;
    applyStimulus(1'b0, 3, 64'h5000, 64'h20);
    pushItem({1'b0, 64'b110});
    waitDone("t6_done", 50);
    checkOutput("t6_nreq", 64'(req_addr_q.size()), 64'd2);
    checkOutput("t6_addr0", qAddr(0), 64'h5020);
    checkOutput("t6_elem0", 64'(qElem(0)), 64'd1);
    checkOutput("t6_addr1", qAddr(1), 64'h5040);
    checkOutput("t6_credits", 64'(credit_cnt), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
